ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same open-drain kbdclk/kbddat lines the keyboard receiver uses. It implements request-to-send, device-clocked shifting, odd parity, stop bit and the device ACK check. It raises busy so the top level can mute the receiver while the frame is in progress.

Parameters:
INHIBIT_CYCLES, 12000, system clocks that kbdclk is held low for request-to-send (120 us at 100 MHz; minimum 100 us).
TIMEOUT_CYCLES, 2000000, system clocks from clock release to frame completion before abort (20 ms at 100 MHz).
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on kbdclk_in and kbddat_in.

Ports:
clk  in  1  system clock (100 MHz).
rst_n  in  1  asynchronous active-low reset.
start  in  1  request to transmit tx_byte; accepted only when busy=0.
tx_byte  in  8  command byte; captured on the cycle start is accepted.
busy  out  1  high from the cycle after acceptance until the done pulse.
done  out  1  one-cycle pulse when the frame ends, whether it succeeded or not.
err  out  1  valid with done: 1 means timeout or missing ACK.
kbdclk_in  in  1  raw kbdclk pad value (asynchronous).
kbddat_in  in  1  raw kbddat pad value (asynchronous).
kbdclk_oe  out  1  1 drives kbdclk low; 0 releases it (pull-up).
kbddat_oe  out  1  1 drives kbddat low; 0 releases it.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift register 0, counters 0. Both lines are released.
- Inputs pass through SYNC_STAGES flip-flops. A falling edge (fe) is the synchronized clock going 1 then 0, registered for one cycle.
- Parity bit = ~^tx_byte, so the total count of 1s over data plus parity is odd.
- FSM states and transitions:
  - IDLE: when start=1, capture the byte and compute parity. Next cycle: busy=1, kbdclk_oe=1, enter INHIBIT.
  - INHIBIT: count to INHIBIT_CYCLES, then set kbddat_oe=1 (start bit) and enter REQ. kbdclk_oe stays 1 for exactly one more cycle, then goes to 0.
  - REQ: clock is released and the timeout counter starts. The first fe drives bit0 (kbddat_oe = ~bit), then enter DATA.
  - DATA: each fe shifts out the next bit, LSB first, with bit index 1..7 after bit0. After the fe that drove bit7, the next fe drives parity and enters PARITY.
  - PARITY: on the next fe set kbddat_oe=0 (stop bit = released line) and enter STOP.
  - STOP: on the next fe sample synchronized kbddat. 0 means ACK ok; 1 means err pending. Enter WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines are 1. Then pulse done with err, drop busy the same cycle, and return to IDLE.
- Latency: done occurs at least 11 device falling edges after clock release. busy is never high for fewer than INHIBIT_CYCLES+2 system cycles.
- Timeout: if the counter reaches TIMEOUT_CYCLES in any state from REQ through WAIT_IDLE:
  - release both lines;
  - pulse done with err=1;
  - return to IDLE.
- start while busy=1 is ignored. tx_byte is not re-sampled mid-frame.
- A device-originated clock edge seen in IDLE is ignored. The transmitter never drives the lines in IDLE.
- Asynchronous reset mid-frame releases both lines immediately and emits no done.
- kbdclk_oe and kbddat_oe come directly from flops, so they are glitch-free.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - ACK code 8'hFA.
- One sub-module: ps2_line_sync. It provides the synchronizer plus falling-edge detector and is reused by the receiver.

Test Plan:
- Bench setup: simulate with INHIBIT_CYCLES=50 and TIMEOUT_CYCLES=5000. A device model generates a 10 kHz-scaled kbdclk once it sees clock released with data low, samples data on rising edges, and pulls data low on the 11th clock as ACK.
- Send 0xED: device captures bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1. done=1, err=0. busy is high for the whole frame.
- Send 0xF4: device captures parity 0. kbdclk_oe stays high for exactly 50 cycles and kbddat_oe rises before kbdclk_oe falls. done=1, err=0.
- Device model withholds ACK (leaves data high) when sending 0x00 (parity 1): done=1, err=1, both oe=0.
- Device never clocks after the request: done=1 with err=1 at exactly 5000 cycles after clock release; lines are released.
- start pulsed again mid-frame with tx_byte=0xAA: the frame still carries the original byte and there is exactly one done. rst_n asserted mid-DATA: both oe go 0 asynchronously, busy=0, no done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and PS/2 command/response codes.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE} ps2_state_t;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_CODE     = 8'hFA;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes raw kbdclk/kbddat pads and flags kbdclk falling edges.
// clk, rst_n: system clock, async active-low reset
// clk_in, dat_in: raw pad values; clk_s, dat_s: synchronized lines; fe: registered falling-edge pulse
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic fe
);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic clk_prev_q, clk_prev_d, fe_q, fe_d;
  always_comb begin
    clk_sync_d = (clk_sync_q << 1) | SYNC_STAGES'(clk_in);
    dat_sync_d = (dat_sync_q << 1) | SYNC_STAGES'(dat_in);
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fe_d       = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  end
  // lines idle high through their pull-ups, so reset to 1 to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      fe_q       <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      fe_q       <= fe_d;
    end
  end
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fe    = fe_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter with request-to-send and ACK check.
// start/tx_byte: request and byte; busy/done/err: frame status
// kbdclk_in/kbddat_in: raw pads; kbdclk_oe/kbddat_oe: 1 pulls the open-drain line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       kbdclk_in,
  input  logic       kbddat_in,
  output logic       kbdclk_oe,
  output logic       kbddat_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_t state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [8:0] shreg_q, shreg_d;
  logic [3:0] bit_q, bit_d;
  logic ack_err_q, ack_err_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic clk_s, dat_s, fe, in_frame;
  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .clk_in(kbdclk_in), .dat_in(kbddat_in),
    .clk_s(clk_s), .dat_s(dat_s), .fe(fe)
  );
  assign in_frame = state_q inside {REQ, DATA, PARITY, STOP, WAIT_IDLE};
  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    to_d      = in_frame ? to_q + 1'b1 : '0;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    case (state_q)
      IDLE: if (start) begin
        shreg_d   = {~^tx_byte, tx_byte};
        inh_d     = '0;
        bit_d     = '0;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        clk_oe_d  = 1'b1;
        state_d   = INHIBIT;
      end
      // leave one cycle early so clock is held exactly INHIBIT_CYCLES with the start bit overlapping it
      INHIBIT: begin
        inh_d = inh_q + 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 2)) begin
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        if (fe) begin
          dat_oe_d = ~shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bit_d    = 4'd1;
          state_d  = DATA;
        end
      end
      // bits 1..7 then parity come out of the same shifter; bit_q counts bits already driven
      DATA: if (fe) begin
        dat_oe_d = ~shreg_q[0];
        shreg_d  = shreg_q >> 1;
        bit_d    = bit_q + 1'b1;
        state_d  = (bit_q == 4'd8) ? PARITY : DATA;
      end
      PARITY: if (fe) begin
        dat_oe_d = 1'b0;
        state_d  = STOP;
      end
      STOP: if (fe) begin
        ack_err_d = dat_s;
        state_d   = WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_s & dat_s) begin
        done_d  = 1'b1;
        err_d   = ack_err_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_frame && to_q == TW'(TIMEOUT_CYCLES)) begin
      state_d  = IDLE;
      done_d   = 1'b1;
      err_d    = 1'b1;
      busy_d   = 1'b0;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inh_q     <= '0;
      to_q      <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign kbdclk_oe = clk_oe_q;
  assign kbddat_oe = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven bench for ps2_host_tx with a behavioural PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int H = 20;
  localparam int INH = 50;
  localparam int TMO = 5000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic busy, done, err, kbdclk_oe, kbddat_oe;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0, dev_abort = 1'b0;
  logic kbdclk, kbddat;
  int checks = 0, failures = 0;
  int oe_run = 0, last_run = 0, done_cnt = 0;
  logic dat_with_clk = 1'b0;
  longint rel_t = 0;
  assign kbdclk = ~(kbdclk_oe | dev_clk_low);
  assign kbddat = ~(kbddat_oe | dev_dat_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_byte(tx_byte),
    .busy(busy), .done(done), .err(err),
    .kbdclk_in(kbdclk), .kbddat_in(kbddat),
    .kbdclk_oe(kbdclk_oe), .kbddat_oe(kbddat_oe)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (kbdclk_oe) begin
      oe_run <= oe_run + 1;
      dat_with_clk <= kbddat_oe;
    end else if (oe_run != 0) begin
      last_run <= oe_run;
      oe_run <= 0;
      rel_t <= $time;
    end
    if (done) done_cnt <= done_cnt + 1;
  end
  typedef struct {
    logic [7:0] tx;
    bit         ack;
    logic [9:0] frame;
    bit         exp_err;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = kbdclk & ~kbddat;
    end
  endtask
  task automatic wait_done(output bit ok, output logic e, output longint t);
    ok = 1'b0;
    e = 1'b0;
    t = 0;
    for (int i = 0; i < TMO + 1000 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        e = err;
        t = $time;
      end
    end
  endtask
  task automatic dev_frame(input bit ack, output logic [9:0] got, output bit busy_ok);
    busy_ok = 1'b1;
    got = '0;
    for (int i = 0; i < 11 && !dev_abort; i++) begin
      if (i == 10 && ack) dev_dat_low = 1'b1;
      repeat (H) @(posedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(posedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) got[i] = kbddat;
      if (!busy) busy_ok = 1'b0;
    end
    repeat (2) @(posedge clk);
    dev_dat_low = 1'b0;
  endtask
  initial begin
    bit ok, bok;
    logic e;
    logic [9:0] got;
    longint t;
    int d0;
    vecs[0] = '{CMD_SET_LEDS, 1'b1, 10'h3ED, 1'b0};
    vecs[1] = '{CMD_ENABLE,   1'b1, 10'h2F4, 1'b0};
    vecs[2] = '{8'h00,        1'b0, 10'h300, 1'b1};
    vecs[3] = '{CMD_RESET,    1'b1, 10'h3FF, 1'b0};
    vecs[4] = '{8'h01,        1'b1, 10'h201, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_oe", {kbdclk_oe, kbddat_oe}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
    end
    chk("idle_edges_ignored", {busy, done, kbdclk_oe, kbddat_oe}, 0);
    foreach (vecs[i]) begin
      d0 = done_cnt;
      send_start(vecs[i].tx);
      wait_rts(ok);
      chk("rts_seen", ok, 1);
      dev_frame(vecs[i].ack, got, bok);
      wait_done(ok, e, t);
      chk("done_seen", ok, 1);
      chk("frame_bits", got, vecs[i].frame);
      chk("err", e, vecs[i].exp_err);
      chk("busy_whole_frame", bok, 1);
      chk("inhibit_len", last_run, INH);
      chk("start_bit_before_release", dat_with_clk, 1);
      chk("lines_released", {kbdclk_oe, kbddat_oe}, 0);
      chk("busy_low_after", busy, 0);
      repeat (5) @(negedge clk);
      chk("one_done", done_cnt - d0, 1);
    end
    send_start(CMD_ENABLE);
    wait_done(ok, e, t);
    chk("timeout_done", ok, 1);
    chk("timeout_err", e, 1);
    chk("timeout_cycles", 32'((t - rel_t) / 10), TMO);
    chk("timeout_released", {kbdclk_oe, kbddat_oe, busy}, 0);
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    send_start(CMD_SET_LEDS);
    wait_rts(ok);
    fork
      dev_frame(1'b1, got, bok);
      begin
        repeat (6 * H) @(posedge clk);
        @(negedge clk);
        tx_byte = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(ok, e, t);
    chk("midstart_frame", got, 10'h3ED);
    repeat (300) @(negedge clk);
    chk("midstart_one_done", done_cnt - d0, 1);
    chk("midstart_idle", {busy, kbdclk_oe, kbddat_oe}, 0);
    d0 = done_cnt;
    send_start(CMD_RESET);
    wait_rts(ok);
    fork
      dev_frame(1'b1, got, bok);
      begin
        repeat (9 * H) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_oe_async", {kbdclk_oe, kbddat_oe}, 0);
        chk("rst_busy", busy, 0);
        dev_abort = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    dev_abort = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", {busy, kbdclk_oe, kbddat_oe}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
